// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared width, owner and state types for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int DATA_W = 16;
  typedef enum logic {OWN_CORE, OWN_DMA} own_t;
  typedef enum logic {ARB, LOCK} state_t;
endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if: core, DMA and memory-port signals of the data-memory arbiter.
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(parameter int ADDR_W = 8);
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wd, c_rdata;
  logic              d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wd, d_rdata;
  logic [ADDR_W-1:0] mem_rwa;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd, mem_rd;
  modport slave (
    input  c_req, c_we, c_addr, c_wd, d_req, d_we, d_lock, d_addr, d_wd, mem_rd,
    output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, mem_rwa, mem_we, mem_wd
  );
  modport master (
    output c_req, c_we, c_addr, c_wd, d_req, d_we, d_lock, d_addr, d_wd, mem_rd,
    input  c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, mem_rwa, mem_we, mem_wd
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection; round-robin tie break under DMEM_ARB_RR_EN.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   c_req,
  input  logic   d_req,
  input  state_t st,
  input  logic   force_c,
`ifdef DMEM_ARB_RR_EN
  input  own_t   last_own,
`endif
  output logic   c_win,
  output logic   d_win
);
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    c_win = st == LOCK ? force_c : c_req && (!d_req || last_own == OWN_DMA);
`else
    c_win = st == LOCK ? force_c : c_req;
`endif
    d_win = d_req && !c_win;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 16-bit data-memory port between core and DMA with bounded DMA lock.
// DMEM_ARB_RR_EN selects round-robin arbitration; otherwise core has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input logic        clk,
  input logic        rst,
  dmem_arb_if.slave  bus
);
  state_t            st;
  logic [7:0]        lock_cnt;
  logic              rsp_vld;
  own_t              rsp_own;
  logic              c_win, d_win, c_g, d_g, force_c, c_rv, d_rv;
  logic [ADDR_W-1:0] rwa;
`ifdef DMEM_ARB_RR_EN
  own_t              last_own;
`endif
  assign force_c = st == LOCK && lock_cnt == 8'(MAX_LOCK) && bus.c_req;
  dmem_arb_pick u_pick (
    .c_req   (bus.c_req),
    .d_req   (bus.d_req),
    .st      (st),
    .force_c (force_c),
`ifdef DMEM_ARB_RR_EN
    .last_own(last_own),
`endif
    .c_win   (c_win),
    .d_win   (d_win)
  );
  always_comb begin
    c_g          = c_win && !rst;
    d_g          = d_win && !rst;
    rwa          = c_g ? bus.c_addr : d_g ? bus.d_addr : '0;
    c_rv         = rsp_vld && !rst && rsp_own == OWN_CORE;
    d_rv         = rsp_vld && !rst && rsp_own == OWN_DMA;
    bus.c_gnt    = c_g;
    bus.d_gnt    = d_g;
    bus.mem_rwa  = rwa;
    bus.mem_we   = (c_g && bus.c_we) || (d_g && bus.d_we);
    bus.mem_wd   = c_g ? bus.c_wd : d_g ? bus.d_wd : '0;
    bus.c_rvalid = c_rv;
    bus.d_rvalid = d_rv;
    bus.c_rdata  = c_rv ? bus.mem_rd : '0;
    bus.d_rdata  = d_rv ? bus.mem_rd : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ARB;
      lock_cnt <= '0;
      rsp_vld  <= 1'b0;
      rsp_own  <= OWN_CORE;
`ifdef DMEM_ARB_RR_EN
      last_own <= OWN_DMA;
`endif
    end else begin
      rsp_vld <= (c_g && !bus.c_we) || (d_g && !bus.d_we);
      rsp_own <= d_g ? OWN_DMA : OWN_CORE;
`ifdef DMEM_ARB_RR_EN
      if (c_g || d_g) last_own <= d_g ? OWN_DMA : OWN_CORE;
`endif
      if (st == ARB) begin
        if (d_g && bus.d_lock) begin
          st       <= LOCK;
          lock_cnt <= 8'd1;
        end
      end else if (d_g && bus.d_lock) begin
        // saturate so an idle core can still force a slot later
        lock_cnt <= lock_cnt == 8'(MAX_LOCK) ? lock_cnt : lock_cnt + 8'd1;
      end else begin
        st       <= ARB;
        lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus random stimulus against a cycle-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;
  localparam int AW = 8;
  localparam int ML = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dmem_arb_if #(.ADDR_W(AW)) bus ();
  dmem_arbiter #(.ADDR_W(AW), .MAX_LOCK(ML)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_rwa] <= bus.mem_wd;
    bus.mem_rd <= mem[bus.mem_rwa];
  end
  logic [15:0] ref_mem [256];
  bit          m_lock, m_last_d, m_pend, m_pend_d;
  int          m_cnt;
  logic [15:0] m_pend_data, ewd;
  logic [7:0]  ea;
  bit          ec, ed, ewe, c_hold, d_hold, obs_c;
  int          n_tests, n_fail;
  logic [4:0]  pat;
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic setc(input bit req, input bit we, input logic [7:0] a, input logic [15:0] wd);
    bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wd = wd;
  endtask
  task automatic setd(input bit req, input bit we, input logic [7:0] a, input logic [15:0] wd, input bit lk);
    bus.d_req = req; bus.d_we = we; bus.d_addr = a; bus.d_wd = wd; bus.d_lock = lk;
  endtask
  task automatic cycle(input bit r);
    bit cv, dv;
    rst = r;
    #1;
    ec = 1'b0;
    ed = 1'b0;
    if (m_lock) begin
      if (m_cnt >= ML && bus.c_req) ec = 1'b1;
      else ed = bus.d_req;
    end else begin
`ifdef DMEM_ARB_RR_EN
      if (bus.c_req && bus.d_req) begin
        ec = m_last_d;
        ed = !m_last_d;
      end else begin
        ec = bus.c_req;
        ed = bus.d_req;
      end
`else
      ec = bus.c_req;
      ed = bus.d_req && !bus.c_req;
`endif
    end
    if (r) begin
      ec = 1'b0;
      ed = 1'b0;
    end
    ea  = ec ? bus.c_addr : ed ? bus.d_addr : 8'h0;
    ewe = ec ? bus.c_we : ed ? bus.d_we : 1'b0;
    ewd = ec ? bus.c_wd : ed ? bus.d_wd : 16'h0;
    cv  = !r && m_pend && !m_pend_d;
    dv  = !r && m_pend && m_pend_d;
    obs_c = bus.c_gnt;
    chk("gnt", 48'({bus.c_gnt, bus.d_gnt}), 48'({ec, ed}));
    chk("mem", 48'({bus.mem_we, bus.mem_rwa, bus.mem_wd}), 48'({ewe, ea, ewd}));
    chk("c_rsp", 48'({bus.c_rvalid, bus.c_rdata}), 48'({cv, cv ? m_pend_data : 16'h0}));
    chk("d_rsp", 48'({bus.d_rvalid, bus.d_rdata}), 48'({dv, dv ? m_pend_data : 16'h0}));
    @(posedge clk);
    if (r) begin
      m_lock = 1'b0; m_cnt = 0; m_pend = 1'b0; m_last_d = 1'b1;
    end else begin
      m_pend      = (ec || ed) && !ewe;
      m_pend_d    = ed;
      m_pend_data = ref_mem[ea];
      if (ewe) ref_mem[ea] = ewd;
      if (ec || ed) m_last_d = ed;
      if (!m_lock) begin
        if (ed && bus.d_lock) begin
          m_lock = 1'b1;
          m_cnt  = 1;
        end
      end else if (ed && bus.d_lock) begin
        if (m_cnt < ML) m_cnt++;
      end else begin
        m_lock = 1'b0;
        m_cnt  = 0;
      end
    end
    c_hold = bus.c_req && !ec;
    d_hold = bus.d_req && !ed;
    @(negedge clk);
  endtask
  task automatic gen();
    if (!c_hold)
      setc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
    if (!d_hold)
      setd(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 3) != 0));
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    setc(0, 0, 0, 0);
    setd(0, 0, 0, 0, 0);
    @(negedge clk);
    cycle(1);
    cycle(1);
    chk("rst_cnt", 48'(u_dut.lock_cnt), 48'd0);
    for (int i = 0; i < 32; i++) begin
      setc(1, 1, 8'(i), 16'h0);
      cycle(0);
    end
    setc(1, 1, 8'h12, 16'hBEEF);
    cycle(0);
    setc(1, 0, 8'h12, 16'h0);
    cycle(0);
    setc(0, 0, 0, 0);
    chk("beef", 48'({bus.c_rvalid, bus.c_rdata, bus.d_rvalid}), 48'({1'b1, 16'hBEEF, 1'b0}));
    cycle(0);
    cycle(1);
    setc(1, 0, 8'h1, 16'h0);
    setd(1, 0, 8'h2, 16'h0, 0);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(0);
      pat = {pat[3:0], obs_c};
    end
`ifdef DMEM_ARB_RR_EN
    chk("tie", 48'(pat[3:0]), 48'(4'b1010));
`else
    chk("tie", 48'(pat[3:0]), 48'(4'b1111));
`endif
    setc(0, 0, 0, 0);
    setd(1, 0, 8'h3, 16'h0, 1);
    cycle(1);
    pat = '0;
    cycle(0);
    pat = {pat[3:0], obs_c};
    setc(1, 0, 8'h4, 16'h0);
    cycle(0);
    pat = {pat[3:0], obs_c};
    setd(1, 0, 8'h5, 16'h0, 0);
    cycle(0);
    pat = {pat[3:0], obs_c};
    setd(0, 0, 0, 0, 0);
    cycle(0);
    pat = {pat[3:0], obs_c};
    chk("lock", 48'(pat[3:0]), 48'(4'b0001));
    setc(0, 0, 0, 0);
    setd(1, 0, 8'h6, 16'h0, 1);
    cycle(1);
    pat = '0;
    cycle(0);
    pat = {pat[3:0], obs_c};
    setc(1, 0, 8'h7, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(0);
      pat = {pat[3:0], obs_c};
    end
`ifdef DMEM_ARB_RR_EN
    chk("force", 48'(pat), 48'(5'b00010));
`else
    chk("force", 48'(pat), 48'(5'b00011));
`endif
    setd(0, 0, 0, 0, 0);
    setc(1, 0, 8'h12, 16'h0);
    cycle(0);
    setc(0, 0, 0, 0);
    cycle(0);
    setc(1, 0, 8'h12, 16'h0);
    cycle(0);
    setc(0, 0, 0, 0);
    cycle(1);
    chk("rst_st", 48'(u_dut.st), 48'(ARB));
    chk("rst_cnt2", 48'(u_dut.lock_cnt), 48'd0);
    for (int i = 0; i < 3; i++) cycle(0);
    c_hold = 1'b0;
    d_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      gen();
      cycle(1'($urandom_range(0, 63) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter in front of the 16-bit single-port data memory, which has a 1-cycle registered read.
- Shares the memory's one read/write port between the core load/store path (`c_*`) and the DMA/debug path (`d_*`).
- Issues at most one access per cycle and routes each read response to the requester that issued it.
- Supports a bounded DMA burst lock, so multi-word transfers are not interleaved with core accesses.

## Interface
- `ADDR_W`, 8: memory word-address width.
- `MAX_LOCK`, 8: maximum consecutive locked DMA grants before one core slot is forced; legal range 1..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `c_req`  in  1  core requests an access; held with fields stable until `c_gnt`.
- `c_we`  in  1  core write (1) / read (0).
- `c_addr`  in  ADDR_W  core word address.
- `c_wd`  in  16  core write data.
- `c_gnt`  out  1  core access accepted this cycle.
- `c_rvalid`  out  1  core read data valid.
- `c_rdata`  out  16  core read data.
- `d_req`, `d_we`, `d_addr`, `d_wd`, `d_gnt`, `d_rvalid`, `d_rdata`: same as the `c_*` set, for DMA.
- `d_lock`  in  1  qualifies `d_req`: keep ownership after this grant.
- `mem_rwa`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wd`  out  16  memory write data.
- `mem_rd`  in  16  memory registered read data.

## Operation
- **Grants:**
  - `c_gnt` and `d_gnt` are combinational from the requests and the current state.
  - They are mutually exclusive; neither is asserted without its `req`.
- **Memory port:**
  - The winner's `addr`/`we`/`wd` drive `mem_*` in the same cycle.
  - With no winner: `mem_we`=0, `mem_rwa`=0, `mem_wd`=0.
- **States:** `ARB`, `LOCK`.
  - In `ARB`, the winner is chosen by the priority policy (see Configuration).
  - `ARB` → `LOCK` when DMA is granted with `d_lock`=1. `lock_cnt` is set to 1.
  - In `LOCK`, only DMA may be granted. The core is stalled (`c_gnt`=0).
  - `LOCK` → `ARB` when DMA is granted with `d_lock`=0.
  - `LOCK` → `ARB` when `d_req`=0 in any `LOCK` cycle; this releases the lock.
  - In `LOCK`, each locked DMA grant increments `lock_cnt`.
  - Force rule: when `lock_cnt`==`MAX_LOCK` and `c_req`=1, the core gets the next grant. The state returns to `ARB` and the DMA must win arbitration again to re-lock.
- **Response tracking:**
  - A registered pair `rsp_vld`/`rsp_own` records each granted read.
  - Writes produce no response.
  - In the cycle after the grant, the owner's `rvalid`=1. Its `rdata` = `mem_rd`, combinational pass-through.
  - The non-owner's `rdata` = 0.
- **Read/write ordering:** a read issued the cycle after a write to the same address returns the new data. The memory is read-before-write within a single cycle only.
- **Reset:**
  - `rst` forces state `ARB`, `lock_cnt`=0, `rsp_vld`=0, `last_own`=DMA (so the core wins the first tie).
  - Grants are still evaluated during `rst`, but all `mem_we` are forced to 0 and all `gnt` are forced to 0.
  - A pending response is dropped; no `rvalid` appears in the cycle after `rst`.
- **Output values during and right after reset:** `c_gnt`, `d_gnt`, `c_rvalid`, `d_rvalid`, `mem_we` are 0; `c_rdata`, `d_rdata`, `mem_rwa`, `mem_wd` are 0.

## Timing
- Grant latency 0: `gnt` in the same cycle as `req` when that requester wins.
- Read latency 1: `rvalid` at cycle N+1 for a grant at N.
- Writes are committed at the end of the grant cycle.
- Throughput: one access per cycle, back-to-back, regardless of which requester owns it.
- Simultaneous requests in `ARB` are resolved by the policy. The loser holds and is granted no later than the next cycle in round-robin mode.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin in `ARB`. On a tie, the requester not recorded in `last_own` wins.
  - `last_own` updates on every grant.
- `DMEM_ARB_RR_EN` undefined:
  - Fixed priority, core over DMA, in `ARB`.
  - `last_own` is not implemented.
  - DMA can starve while the core requests continuously. This is accepted.
- The lock, force rule and response path are identical in both modes.

## Structure
- Package `dmem_arb_pkg`:
  - `DATA_W`=16.
  - Owner typedef (`OWN_CORE`, `OWN_DMA`).
  - State typedef (`ARB`, `LOCK`).
- Sub-module `dmem_arb_pick`: combinational winner selection from `c_req`, `d_req`, state, force flag, and `last_own`. `last_own` is present only under `DMEM_ARB_RR_EN`.
- Registers stay in `dmem_arbiter`.

## Test plan
- **Core write then read:** core writes 0xBEEF to address 0x12, then reads 0x12 → `c_gnt` in both cycles; `c_rvalid`=1 and `c_rdata`=0xBEEF one cycle after the read grant; `d_rvalid` stays 0.
- **Continuous tie, round-robin:** both request continuously under `DMEM_ARB_RR_EN` → grants alternate C, D, C, D starting with core after reset. Without the macro → core only.
- **DMA lock:** DMA with `d_lock`=1 for 4 reads, last with `d_lock`=0, while `c_req`=1 → 4 consecutive `d_gnt`, then `c_gnt`; all 4 `d_rvalid` on the cycles following each grant.
- **Force rule:** `MAX_LOCK`=3, DMA holds `d_lock`=1 indefinitely, `c_req`=1 → 3 DMA grants, then 1 core grant, then DMA may re-lock.
- **Reset mid-read:** `rst` asserted in the cycle after a core read grant → `c_rvalid`=0, `c_rdata`=0, state `ARB`, `lock_cnt` 0.
- **Idle:** no requests → `mem_we`=0, `mem_rwa`=0, no `rvalid`.
